// File: rtl/pc_gen_if.sv
// Fetch request channel between the PC generator and IF: PC plus epoch tag
// offered on a valid/ready handshake.
interface pc_gen_if #(
    parameter int XLEN    = 32,
    parameter int EPOCH_W = 2
) ();
    logic               pc_valid;
    logic               pc_ready;
    logic [XLEN-1:0]    pc;
    logic [EPOCH_W-1:0] pc_epoch;

    modport master (
        output pc_valid,
        output pc,
        output pc_epoch,
        input  pc_ready
    );

    modport slave (
        input  pc_valid,
        input  pc,
        input  pc_epoch,
        output pc_ready
    );
endinterface

// File: rtl/pc_gen.sv
// Fetch-stage PC generator: sequential advance on accepted fetches, trap/branch
// redirects with epoch tagging, and a debug halt/resume FSM.
module pc_gen #(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_VEC  = XLEN'(32'h8000_0000),
    parameter int              INC_BYTES  = 4,
    parameter int              ALIGN_BITS = 2,
    parameter int              EPOCH_W    = 2
) (
    input  logic            clk,
    input  logic            rst,
    pc_gen_if.master        fetch,
    input  logic            br_valid,
    input  logic [XLEN-1:0] br_target,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_target,
    input  logic            halt_req,
    input  logic            resume,
    output logic            halted,
    output logic            misalign
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    localparam logic [XLEN-1:0] LOW_MASK = XLEN'((64'd1 << ALIGN_BITS) - 64'd1);
    localparam logic [XLEN-1:0] INC_VAL  = XLEN'(INC_BYTES);

    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] t);
        return t & ~LOW_MASK;
    endfunction

    function automatic logic low_bits_set(input logic [XLEN-1:0] t);
        return (t & LOW_MASK) != {XLEN{1'b0}};
    endfunction

    state_t             state_r;
    state_t             state_nxt_s;
    logic [XLEN-1:0]    pc_r;
    logic [XLEN-1:0]    pc_nxt_s;
    logic [EPOCH_W-1:0] epoch_r;
    logic [EPOCH_W-1:0] epoch_nxt_s;
    logic               misalign_r;
    logic               misalign_nxt_s;
    logic               redir_s;
    logic [XLEN-1:0]    target_s;
    logic               fire_s;

    assign fire_s = (state_r == ST_RUN) && fetch.pc_ready;

    // Redirect arbitration: trap always wins, branches are dropped while halted.
    always_comb begin
        redir_s  = 1'b0;
        target_s = br_target;
        if (trap_valid) begin
            redir_s  = 1'b1;
            target_s = trap_target;
        end else if (br_valid && (state_r != ST_HALT)) begin
            redir_s  = 1'b1;
            target_s = br_target;
        end else begin
            redir_s  = 1'b0;
            target_s = br_target;
        end
    end

    // Next PC, epoch and misalign flag; a redirect overrides any handshake.
    always_comb begin
        pc_nxt_s       = pc_r;
        epoch_nxt_s    = epoch_r;
        misalign_nxt_s = 1'b0;
        if (redir_s) begin
            pc_nxt_s       = align_pc(target_s);
            epoch_nxt_s    = epoch_r + EPOCH_W'(1);
            misalign_nxt_s = low_bits_set(target_s);
        end else if (fire_s) begin
            pc_nxt_s = pc_r + INC_VAL;
        end else begin
            pc_nxt_s = pc_r;
        end
    end

    // Mode transitions; halt_req dominates resume and trap while halted.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_BOOT: begin
                if (halt_req) begin
                    state_nxt_s = ST_HALT;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_RUN: begin
                if (halt_req) begin
                    state_nxt_s = ST_HALT;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_HALT: begin
                if (halt_req) begin
                    state_nxt_s = ST_HALT;
                end else if (resume || trap_valid) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_HALT;
                end
            end
            default: begin
                state_nxt_s = ST_BOOT;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= ST_BOOT;
            pc_r       <= RESET_VEC;
            epoch_r    <= {EPOCH_W{1'b0}};
            misalign_r <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            pc_r       <= pc_nxt_s;
            epoch_r    <= epoch_nxt_s;
            misalign_r <= misalign_nxt_s;
        end
    end

    assign fetch.pc_valid = (state_r == ST_RUN);
    assign fetch.pc       = pc_r;
    assign fetch.pc_epoch = epoch_r;
    assign halted         = (state_r == ST_HALT);
    assign misalign       = misalign_r;

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: a reference model checked every cycle plus
// hand-computed expectations along the test sequence.
module tb_pc_gen;

    logic        clk;
    logic        rst;
    logic        br_valid;
    logic [31:0] br_target;
    logic        trap_valid;
    logic [31:0] trap_target;
    logic        halt_req;
    logic        resume;
    logic        halted;
    logic        misalign;

    pc_gen_if #(.XLEN(32), .EPOCH_W(2)) fif ();

    pc_gen dut (
        .clk         (clk),
        .rst         (rst),
        .fetch       (fif),
        .br_valid    (br_valid),
        .br_target   (br_target),
        .trap_valid  (trap_valid),
        .trap_target (trap_target),
        .halt_req    (halt_req),
        .resume      (resume),
        .halted      (halted),
        .misalign    (misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: mode 0=boot, 1=run, 2=halt
    longint m_pc;
    int     m_ep;
    int     m_mode;
    bit     m_mis;

    always @(posedge clk or negedge rst) begin
        longint tgt;
        bit     take;
        if (!rst) begin
            m_pc   <= 64'h8000_0000;
            m_ep   <= 0;
            m_mode <= 0;
            m_mis  <= 1'b0;
        end else begin
            take = trap_valid || (br_valid && m_mode != 2);
            tgt  = trap_valid ? longint'(trap_target) : longint'(br_target);
            if (take) begin
                m_pc  <= tgt - (tgt % 4);
                m_ep  <= (m_ep + 1) % 4;
                m_mis <= (tgt % 4) != 0;
            end else begin
                m_mis <= 1'b0;
                if (m_mode == 1 && fif.pc_ready) m_pc <= (m_pc + 4) % 64'h1_0000_0000;
            end
            if (m_mode == 2) m_mode <= (!halt_req && (resume || trap_valid)) ? 1 : 2;
            else             m_mode <= halt_req ? 2 : 1;
        end
    end

    // Literal expectations posted by the stimulus for the next check point
    bit          lit_valid = 1'b0;
    string       lit_name  = "";
    logic [31:0] lit_pc;
    logic [1:0]  lit_ep;
    logic        lit_pv, lit_hl, lit_mis;
    bit          chk_en = 1'b0;
    logic        probe  = 1'b0;

    function automatic void cmp(string n, longint act, longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", n, act, exp, $time);
        end
    endfunction

    // Single compare process: model every cycle, literals when posted
    always @(negedge clk or posedge probe) begin
        if (chk_en) begin
            cmp("model_pc",       longint'(fif.pc),       m_pc);
            cmp("model_epoch",    longint'(fif.pc_epoch), longint'(m_ep));
            cmp("model_pc_valid", longint'(fif.pc_valid), longint'(m_mode == 1));
            cmp("model_halted",   longint'(halted),       longint'(m_mode == 2));
            cmp("model_misalign", longint'(misalign),     longint'(m_mis));
            if (lit_valid) begin
                cmp({lit_name, "_pc"},       longint'(fif.pc),       longint'(lit_pc));
                cmp({lit_name, "_epoch"},    longint'(fif.pc_epoch), longint'(lit_ep));
                cmp({lit_name, "_pc_valid"}, longint'(fif.pc_valid), longint'(lit_pv));
                cmp({lit_name, "_halted"},   longint'(halted),       longint'(lit_hl));
                cmp({lit_name, "_misalign"}, longint'(misalign),     longint'(lit_mis));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic post(input string n, input logic [31:0] p, input logic [1:0] e,
                        input logic pv, input logic hl, input logic mi);
        lit_name  = n;
        lit_pc    = p;
        lit_ep    = e;
        lit_pv    = pv;
        lit_hl    = hl;
        lit_mis   = mi;
        lit_valid = 1'b1;
    endtask

    task automatic expect_at_negedge(input string n, input logic [31:0] p, input logic [1:0] e,
                                     input logic pv, input logic hl, input logic mi);
        post(n, p, e, pv, hl, mi);
        @(negedge clk);
        #1;
        lit_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst         = 1'b0;
        fif.pc_ready = 1'b1;
        br_valid    = 1'b0;
        br_target   = 32'h0;
        trap_valid  = 1'b0;
        trap_target = 32'h0;
        halt_req    = 1'b0;
        resume      = 1'b0;
        #2 chk_en = 1'b1;
        #5 rst = 1'b1;
        expect_at_negedge("boot", 32'h8000_0000, 2'd0, 1'b0, 1'b0, 1'b0);
        tick(); expect_at_negedge("run0", 32'h8000_0000, 2'd0, 1'b1, 1'b0, 1'b0);
        tick(); expect_at_negedge("run1", 32'h8000_0004, 2'd0, 1'b1, 1'b0, 1'b0);
        tick(); expect_at_negedge("run2", 32'h8000_0008, 2'd0, 1'b1, 1'b0, 1'b0);

        fif.pc_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick(); expect_at_negedge("stall", 32'h8000_0008, 2'd0, 1'b1, 1'b0, 1'b0);
        end
        fif.pc_ready = 1'b1;
        tick(); expect_at_negedge("unstall", 32'h8000_000C, 2'd0, 1'b1, 1'b0, 1'b0);

        br_valid = 1'b1; br_target = 32'h8000_1000;
        trap_valid = 1'b1; trap_target = 32'h8000_0100;
        tick(); expect_at_negedge("prio", 32'h8000_0100, 2'd1, 1'b1, 1'b0, 1'b0);
        trap_valid = 1'b0; br_target = 32'h8000_1002;
        tick(); expect_at_negedge("misal", 32'h8000_1000, 2'd2, 1'b1, 1'b0, 1'b1);
        br_valid = 1'b0;
        tick(); expect_at_negedge("misal_end", 32'h8000_1004, 2'd2, 1'b1, 1'b0, 1'b0);

        br_valid = 1'b1; br_target = 32'h8000_0020;
        tick(); expect_at_negedge("pre_wrap0", 32'h8000_0020, 2'd3, 1'b1, 1'b0, 1'b0);
        br_target = 32'h8000_0030;
        tick(); expect_at_negedge("pre_wrap1", 32'h8000_0030, 2'd0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            br_target = 32'h8000_0100 + 32'(i * 16);
            tick();
            expect_at_negedge("wrap", 32'h8000_0100 + 32'(i * 16), 2'((i + 1) % 4), 1'b1, 1'b0, 1'b0);
        end

        br_target = 32'h8000_0010;
        tick(); expect_at_negedge("to_10", 32'h8000_0010, 2'd1, 1'b1, 1'b0, 1'b0);
        br_valid = 1'b0; halt_req = 1'b1;
        tick(); expect_at_negedge("halt", 32'h8000_0014, 2'd1, 1'b0, 1'b1, 1'b0);
        halt_req = 1'b0; br_valid = 1'b1; br_target = 32'h8000_3000;
        tick(); expect_at_negedge("br_in_halt", 32'h8000_0014, 2'd1, 1'b0, 1'b1, 1'b0);
        br_valid = 1'b0; trap_valid = 1'b1; trap_target = 32'h8000_0200;
        tick(); expect_at_negedge("trap_wake", 32'h8000_0200, 2'd2, 1'b1, 1'b0, 1'b0);
        trap_valid = 1'b0; halt_req = 1'b1; fif.pc_ready = 1'b0;
        tick(); expect_at_negedge("halt2", 32'h8000_0200, 2'd2, 1'b0, 1'b1, 1'b0);
        resume = 1'b1;
        tick(); expect_at_negedge("halt_wins", 32'h8000_0200, 2'd2, 1'b0, 1'b1, 1'b0);
        halt_req = 1'b0;
        tick(); expect_at_negedge("resume", 32'h8000_0200, 2'd2, 1'b1, 1'b0, 1'b0);
        resume = 1'b0; fif.pc_ready = 1'b1;
        tick(); expect_at_negedge("after_res", 32'h8000_0204, 2'd2, 1'b1, 1'b0, 1'b0);

        br_valid = 1'b1; br_target = 32'h8000_0040;
        tick(); expect_at_negedge("to_40", 32'h8000_0040, 2'd3, 1'b1, 1'b0, 1'b0);
        br_valid = 1'b0; fif.pc_ready = 1'b0;
        tick();
        #1 rst = 1'b0;
        post("async_rst", 32'h8000_0000, 2'd0, 1'b0, 1'b0, 1'b0);
        #1 probe = 1'b1;
        #1 probe = 1'b0;
        lit_valid = 1'b0;
        #4 rst = 1'b1;
        fif.pc_ready = 1'b1;
        tick(); expect_at_negedge("rerun0", 32'h8000_0000, 2'd0, 1'b1, 1'b0, 1'b0);
        tick(); expect_at_negedge("rerun1", 32'h8000_0004, 2'd0, 1'b1, 1'b0, 1'b0);

        trap_valid = 1'b1; trap_target = 32'hFFFF_FFFC;
        tick(); expect_at_negedge("top", 32'hFFFF_FFFC, 2'd1, 1'b1, 1'b0, 1'b0);
        trap_valid = 1'b0;
        tick(); expect_at_negedge("pc_wrap", 32'h0000_0000, 2'd1, 1'b1, 1'b0, 1'b0);
        trap_valid = 1'b1; trap_target = 32'h8000_0203;
        tick(); expect_at_negedge("trap_mis", 32'h8000_0200, 2'd2, 1'b1, 1'b0, 1'b1);
        trap_valid = 1'b0;
        tick(); expect_at_negedge("trap_mis_end", 32'h8000_0204, 2'd2, 1'b1, 1'b0, 1'b0);

        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
